// File: rtl/bvashr_sge_skolem_checker.sv
// Sequencer/checker around a combinational Skolem block for (x >>a s) >=s t.
// A query (s,t) is driven to the Skolem block, and its witness is checked.
// If the witness fails, every x is tried in order. The result reports the
// witness, satisfiability, and whether the Skolem block was right.
module bvashr_sge_skolem_checker #(
  parameter int W      = 4,
  parameter int SK_LAT = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [W-1:0]     q_s,
  input  logic [W-1:0]     q_t,
  output logic [W-1:0]     sk_s,
  output logic [W-1:0]     sk_t,
  input  logic [W-1:0]     sk_x,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [W-1:0]     r_x,
  output logic             r_sat,
  output logic             r_sk_ok,
  output logic [W:0]       r_iters,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CW = (SK_LAT > 1) ? $clog2(SK_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_wait;
  logic [W-1:0]   r_cand;

  logic           w_eval_last;
  logic           w_cand_last;
  logic           w_sk_pass;
  logic           w_cand_pass;

  // Constraint check: arithmetic shift right, shifts of W or more give
  // W copies of the sign bit; the comparison is signed at width W.
  function automatic logic check(input logic [W-1:0] x,
                                 input logic [W-1:0] s,
                                 input logic [W-1:0] t);
    logic [W-1:0] y;
    int unsigned  sh;
    sh = 32'(s);
    if (sh >= 32'(W)) begin
      y = {W{x[W-1]}};
    end else begin
      y = W'($signed(x) >>> sh);
    end
    return $signed(y) >= $signed(t);
  endfunction

  assign w_eval_last = (r_wait == CW'(SK_LAT - 1));
  assign w_cand_last = (r_cand == '1);
  // sk_x only reaches the result through w_sk_pass in the last EVAL cycle.
  assign w_sk_pass   = check(sk_x, sk_s, sk_t);
  assign w_cand_pass = check(r_cand, sk_s, sk_t);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_next  = r_state;
    q_ready = 1'b0;
    r_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        q_ready = 1'b1;
        if (q_valid) begin
          w_next = S_EVAL;
        end
      end
      S_EVAL: begin
        if (w_eval_last) begin
          w_next = w_sk_pass ? S_DONE : S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (w_cand_pass || w_cand_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        r_valid = 1'b1;
        if (r_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Query latch, wait counter, search candidate and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_s    <= '0;
      sk_t    <= '0;
      r_wait  <= '0;
      r_cand  <= '0;
      r_x     <= '0;
      r_sat   <= 1'b0;
      r_sk_ok <= 1'b0;
      r_iters <= '0;
      err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (q_valid) begin
            sk_s    <= q_s;
            sk_t    <= q_t;
            r_wait  <= '0;
            r_iters <= '0;
          end
        end
        S_EVAL: begin
          if (!w_eval_last) begin
            r_wait <= r_wait + 1'b1;
          end else if (w_sk_pass) begin
            r_x     <= sk_x;
            r_sat   <= 1'b1;
            r_sk_ok <= 1'b1;
            r_iters <= '0;
          end else begin
            r_cand  <= '0;
            r_iters <= '0;
          end
        end
        S_SEARCH: begin
          // r_iters tracks r_cand, so after this cycle it reads cand+1;
          // on the last candidate it reaches 2^W without wrapping.
          r_iters <= r_iters + 1'b1;
          r_cand  <= r_cand + 1'b1;
          if (w_cand_pass) begin
            r_x     <= r_cand;
            r_sat   <= 1'b1;
            r_sk_ok <= 1'b0;
            if (err_cnt != '1) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end else if (w_cand_last) begin
            r_x     <= '0;
            r_sat   <= 1'b0;
            r_sk_ok <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
